// File: rtl/evo_xb_pmux_pkg.sv
// Shared types and index helpers for the registered, arbitrated crossbar pin mux.
package evo_xb_pmux_pkg;

  typedef enum logic [1:0] {
    PMUX_IDLE   = 2'd0,
    PMUX_OWNED  = 2'd1,
    PMUX_SWITCH = 2'd2
  } pmux_state_t;

  // Flat request/grant bit index of channel m on pin p.
  function automatic int unsigned pin_idx(int unsigned m, int unsigned p, int unsigned num_pins);
    return m * num_pins + p;
  endfunction

  function automatic int unsigned owner_width(int unsigned mux_width);
    return (mux_width > 1) ? $clog2(mux_width) : 1;
  endfunction

endpackage

// File: rtl/evo_xb_pmux_pin.sv
// One pin of the crossbar mux: priority arbiter, ownership FSM, dead-time counter.
// Build option EVO_XB_PMUX_LOCK_EN makes ownership non-preemptive.
// state       | meaning
// PMUX_IDLE   | pin released, outputs 0
// PMUX_OWNED  | one channel granted, its dir/out registered onto the pin
// PMUX_SWITCH | hand-over dead-time, pin claimed but tristated
module evo_xb_pmux_pin
  import evo_xb_pmux_pkg::*;
#(
  parameter int MUX_WIDTH = 4,
  parameter int DEADTIME  = 2,
  parameter int OWNER_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MUX_WIDTH-1:0] req_i,
  input  logic [MUX_WIDTH-1:0] dir_i,
  input  logic [MUX_WIDTH-1:0] out_i,
  output logic [MUX_WIDTH-1:0] grant_o,
  output logic [OWNER_W-1:0]   owner_o,
  output logic                 port_dir_o,
  output logic                 port_out_o,
  output logic                 port_en_o
);

  localparam int CNT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (DEADTIME > 0) ? CNT_W'(DEADTIME - 1) : '0;

  pmux_state_t            state_q, state_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MUX_WIDTH-1:0]   grant_q, grant_d;
  logic                   en_q, en_d;
  logic                   dir_q, dir_d;
  logic                   out_q, out_d;

  logic                   any_req;
  logic [OWNER_W-1:0]     winner;
  logic                   owner_held;
  logic                   preempt;

  always_comb begin
    any_req = |req_i;
    winner  = '0;
    for (int m = MUX_WIDTH - 1; m >= 0; m--) begin
      if (req_i[m]) winner = OWNER_W'(m);
    end
  end

  assign owner_held = req_i[owner_q];

`ifdef EVO_XB_PMUX_LOCK_EN
  assign preempt = 1'b0;
`else
  assign preempt = any_req && (winner < owner_q);
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      PMUX_IDLE: begin
        if (any_req) begin
          state_d = PMUX_OWNED;
          owner_d = winner;
        end
      end
      PMUX_OWNED: begin
        // A drop and a higher-priority request on the same edge is a single hand-over.
        if (!owner_held || preempt) begin
          if (!any_req) begin
            state_d = PMUX_IDLE;
          end else if (DEADTIME == 0) begin
            owner_d = winner;
          end else begin
            state_d = PMUX_SWITCH;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      PMUX_SWITCH: begin
        if (cnt_q == '0) begin
          if (any_req) begin
            state_d = PMUX_OWNED;
            owner_d = winner;
          end else begin
            state_d = PMUX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = PMUX_IDLE;
    endcase
  end

  always_comb begin
    grant_d = '0;
    en_d    = (state_d != PMUX_IDLE);
    dir_d   = 1'b0;
    out_d   = 1'b0;
    if (state_d == PMUX_OWNED) begin
      grant_d[owner_d] = 1'b1;
      dir_d            = dir_i[owner_d];
      out_d            = out_i[owner_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PMUX_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      en_q    <= 1'b0;
      dir_q   <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
    end
  end

  assign grant_o    = grant_q;
  assign owner_o    = owner_q;
  assign port_dir_o = dir_q;
  assign port_out_o = out_q;
  assign port_en_o  = en_q;

endmodule

// File: rtl/evo_xb_pmux_arb.sv
// Registered, arbitrated pin mux for one crossbar port; regroups channel-major vectors per pin.
// Build option EVO_XB_PMUX_LOCK_EN (handled per pin) selects non-preemptive ownership.
module evo_xb_pmux_arb
  import evo_xb_pmux_pkg::*;
#(
  parameter  int NUM_PINS  = 8,
  parameter  int MUX_WIDTH = 4,
  parameter  int DEADTIME  = 2,
  localparam int OWNER_W   = owner_width(MUX_WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PINS*MUX_WIDTH-1:0] req_i,
  input  logic [NUM_PINS*MUX_WIDTH-1:0] dir_i,
  input  logic [NUM_PINS*MUX_WIDTH-1:0] out_i,
  output logic [NUM_PINS*MUX_WIDTH-1:0] grant_o,
  output logic [NUM_PINS*OWNER_W-1:0]   owner_o,
  output logic [NUM_PINS-1:0]           port_dir_o,
  output logic [NUM_PINS-1:0]           port_out_o,
  output logic [NUM_PINS-1:0]           port_en_o
);

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [MUX_WIDTH-1:0] req_p;
    logic [MUX_WIDTH-1:0] dir_p;
    logic [MUX_WIDTH-1:0] out_p;
    logic [MUX_WIDTH-1:0] grant_p;

    for (genvar m = 0; m < MUX_WIDTH; m++) begin : g_ch
      assign req_p[m] = req_i[pin_idx(m, p, NUM_PINS)];
      assign dir_p[m] = dir_i[pin_idx(m, p, NUM_PINS)];
      assign out_p[m] = out_i[pin_idx(m, p, NUM_PINS)];
      assign grant_o[pin_idx(m, p, NUM_PINS)] = grant_p[m];
    end

    evo_xb_pmux_pin #(
      .MUX_WIDTH (MUX_WIDTH),
      .DEADTIME  (DEADTIME),
      .OWNER_W   (OWNER_W)
    ) u_pin (
      .clk        (clk),
      .reset      (reset),
      .req_i      (req_p),
      .dir_i      (dir_p),
      .out_i      (out_p),
      .grant_o    (grant_p),
      .owner_o    (owner_o[p*OWNER_W +: OWNER_W]),
      .port_dir_o (port_dir_o[p]),
      .port_out_o (port_out_o[p]),
      .port_en_o  (port_en_o[p])
    );
  end

endmodule

// File: tb/tb_evo_xb_pmux_arb.sv
// Scoreboard bench for evo_xb_pmux_arb: directed hand-over scenarios plus random traffic.
module tb_evo_xb_pmux_arb;

  localparam int NP = 8;
  localparam int MW = 4;
  localparam int DT = 2;
  localparam int OW = 2;
`ifdef EVO_XB_PMUX_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct packed {
    logic [NP*MW-1:0] grant;
    logic [NP*OW-1:0] owner;
    logic [NP-1:0]    dir;
    logic [NP-1:0]    out;
    logic [NP-1:0]    en;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NP*MW-1:0]    req_i = '0;
  logic [NP*MW-1:0]    dir_i = '0;
  logic [NP*MW-1:0]    out_i = '0;
  logic [NP*MW-1:0]    grant_o;
  logic [NP*OW-1:0]    owner_o;
  logic [NP-1:0]       port_dir_o;
  logic [NP-1:0]       port_out_o;
  logic [NP-1:0]       port_en_o;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  // Reference pin model: own = current grantee (-1 none), dead = tristate cycles left.
  int own  [NP];
  int last [NP];
  int dead [NP];

  evo_xb_pmux_arb #(.NUM_PINS(NP), .MUX_WIDTH(MW), .DEADTIME(DT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .dir_i      (dir_i),
    .out_i      (out_i),
    .grant_o    (grant_o),
    .owner_o    (owner_o),
    .port_dir_o (port_dir_o),
    .port_out_o (port_out_o),
    .port_en_o  (port_en_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic [31:0] bit_of(input int m, input int p);
    logic [31:0] v;
    v = '0;
    v[m*NP + p] = 1'b1;
    return v;
  endfunction

  function automatic int winner(input logic [NP*MW-1:0] rq, input int p);
    for (int m = 0; m < MW; m++) begin
      if (rq[m*NP + p]) return m;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      own[p]  = -1;
      last[p] = 0;
      dead[p] = 0;
    end
  endtask

  task automatic model_step(input bit r, input logic [NP*MW-1:0] rq, dq, oq);
    exp_t e;
    int   w;
    e = '0;
    if (r) model_reset();
    else begin
      for (int p = 0; p < NP; p++) begin
        w = winner(rq, p);
        if (dead[p] > 0) begin
          dead[p]--;
          if (dead[p] == 0) begin
            own[p] = w;
            if (w >= 0) last[p] = w;
          end
        end else if (own[p] >= 0) begin
          if (!rq[own[p]*NP + p] || (!LOCK && w >= 0 && w < own[p])) begin
            if (w < 0) own[p] = -1;
            else if (DT == 0) begin
              own[p]  = w;
              last[p] = w;
            end else begin
              own[p]  = -1;
              dead[p] = DT;
            end
          end
        end else if (w >= 0) begin
          own[p]  = w;
          last[p] = w;
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      e.en[p] = (own[p] >= 0) || (dead[p] > 0);
      if (own[p] >= 0) begin
        e.grant[own[p]*NP + p] = 1'b1;
        e.dir[p] = dq[own[p]*NP + p];
        e.out[p] = oq[own[p]*NP + p];
      end
      e.owner[p*OW +: OW] = last[p][OW-1:0];
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input bit r, input logic [NP*MW-1:0] rq, dq, oq);
    @(negedge clk);
    reset = r;
    req_i = rq;
    dir_i = dq;
    out_i = oq;
    model_step(r, rq, dq, oq);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, grant_o, '0);
    chk({tag, "_owner"}, 32'(owner_o), '0);
    chk({tag, "_dir"}, 32'(port_dir_o), '0);
    chk({tag, "_out"}, 32'(port_out_o), '0);
    chk({tag, "_en"}, 32'(port_en_o), '0);
  endtask

  // Reset asserted between edges must clear the outputs without waiting for a clock.
  task automatic async_reset_mid();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("grant_o", grant_o, e.grant);
      chk("owner_o", 32'(owner_o), 32'(e.owner));
      chk("port_dir_o", 32'(port_dir_o), 32'(e.dir));
      chk("port_out_o", 32'(port_out_o), 32'(e.out));
      chk("port_en_o", 32'(port_en_o), 32'(e.en));
    end
  end

  initial begin
    logic [31:0] cur;
    logic [31:0] b25, b35, b30, b10;
    b25 = bit_of(2, 5);
    b35 = bit_of(3, 5);
    b30 = bit_of(3, 0);
    b10 = bit_of(1, 0);
    model_reset();
    #1 reset = 1'b1;
    #2 check_zero("por");

    for (int i = 0; i < 3; i++) step(1'b1, '1, $urandom, $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, '1, $urandom, $urandom);
    for (int i = 0; i < 2; i++) step(1'b0, '0, $urandom, $urandom);

    // Single owner on pin 5 with toggling output.
    for (int i = 0; i < 6; i++)
      step(1'b0, b25, $urandom | b25, ($urandom & ~b25) | ((i % 2 == 1) ? b25 : '0));

    // Hand-over on pin 5 from channel 2 to channel 3.
    for (int i = 0; i < 2; i++) step(1'b0, b25 | b35, $urandom, $urandom);
    for (int i = 0; i < 5; i++) step(1'b0, b35, $urandom, $urandom);
    for (int i = 0; i < 2; i++) step(1'b0, '0, $urandom, $urandom);

    // Preemption on pin 0 by channel 1 while channel 3 holds.
    for (int i = 0; i < 3; i++) step(1'b0, b30, $urandom, $urandom);
    for (int i = 0; i < 6; i++) step(1'b0, b30 | b10, $urandom, $urandom);
    for (int i = 0; i < 4; i++) step(1'b0, b10, $urandom, $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, '0, $urandom, $urandom);

    // Only pending requester leaves during dead-time.
    for (int i = 0; i < 3; i++) step(1'b0, b25, $urandom, $urandom);
    step(1'b0, b25 | b35, $urandom, $urandom);
    step(1'b0, b35, $urandom, $urandom);
    for (int i = 0; i < 4; i++) step(1'b0, '0, $urandom, $urandom);

    // Asynchronous reset while pin 5 is in dead-time.
    for (int i = 0; i < 3; i++) step(1'b0, b25, $urandom, $urandom);
    step(1'b0, b35, $urandom, $urandom);
    async_reset_mid();
    for (int i = 0; i < 2; i++) step(1'b1, b35, $urandom, $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, b35, $urandom, $urandom);

    cur = '0;
    for (int i = 0; i < 1500; i++) begin
      cur = cur ^ ($urandom & $urandom & $urandom);
      step(($urandom_range(0, 199) == 0), cur, $urandom, $urandom);
      if (i % 300 == 150) async_reset_mid();
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, $urandom, $urandom);

    @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/evo_xb_pmux_arb.md
# evo_xb_pmux_arb

Registered, arbitrated per-pin multiplexer for one I/O port of the OpenEvo crossbar; successor to the combinational enable-OR pin mux. Each pin has MUX_WIDTH requesting IP channels; a per-pin state machine grants exactly one owner, registers the owner's direction/output onto the pin, and inserts a programmable dead-time (pin tristated) on every owner hand-over. One instance per port (D, E, F, G, Z), each sized independently.

## Interface
- NUM_PINS, 8, pins in the port
- MUX_WIDTH, 4, requesting channels per pin; channel 0 highest priority
- DEADTIME, 2, tristate cycles on owner hand-over (0 = direct hand-over)
- OWNER_W, derived, max(1, clog2(MUX_WIDTH))
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- req_i  input  NUM_PINS*MUX_WIDTH  request; bit m*NUM_PINS+p = channel m wants pin p
- dir_i  input  NUM_PINS*MUX_WIDTH  requested direction (1 = drive), same indexing
- out_i  input  NUM_PINS*MUX_WIDTH  requested output value, same indexing
- grant_o  output  NUM_PINS*MUX_WIDTH  one-hot per pin (or zero); channel m owns pin p
- owner_o  output  NUM_PINS*OWNER_W  current/last owner index per pin, pin p at [p*OWNER_W +: OWNER_W]
- port_dir_o  output  NUM_PINS  pin direction to port
- port_out_o  output  NUM_PINS  pin output value to port
- port_en_o  output  NUM_PINS  pin is under mux control

## Operation
- Per-pin FSM, states IDLE, OWNED, SWITCH; pins fully independent.
- Arbitration: winner = lowest index m with req set.
- IDLE: en/dir/out = 0, no grant. Any req -> OWNED, owner := winner.
- OWNED: grant bit of owner = 1; en = 1; dir/out = owner's dir_i/out_i registered.
  - Owner drops req, no other req -> IDLE.
  - Owner drops req, other req pending -> SWITCH (or OWNED with new winner if DEADTIME=0).
  - Preemption: lower-index req appears while owner holds -> SWITCH (or direct if DEADTIME=0).
- SWITCH: no grant; en = 1, dir = 0, out = 0 (pin tristated, still claimed); counter loads DEADTIME-1 on entry, decrements each cycle. At count 0 re-arbitrate on current req: winner -> OWNED, none -> IDLE. Requests arriving or leaving during SWITCH are honoured at the re-arbitration only.
- owner_o holds the last owner in IDLE/SWITCH; updates on entry to OWNED.
- MUX_WIDTH=1: owner_o constant 0, preemption impossible, SWITCH entered only via config below never (single requester goes OWNED<->IDLE).

## Timing
- Reset (async assert, sync release): all FSMs IDLE, counters 0, grant_o, owner_o, port_dir_o, port_out_o, port_en_o all 0. Reset mid-SWITCH or mid-OWNED drops the pin immediately.
- req sampled at edge N -> grant_o and port_en_o high after edge N (1-cycle latency).
- dir_i/out_i of owner at edge N appear on port after edge N (1-cycle latency, continuous while OWNED).
- Owner drop at edge N -> grant_o low after edge N; pin tristated for exactly DEADTIME cycles; new grant after edge N+DEADTIME.
- Simultaneous owner drop and higher-priority request: treated as one hand-over, single dead-time.
- Requester must not assume ownership until grant_o seen; dir_i/out_i of non-owners ignored.

## Configuration
- EVO_XB_PMUX_LOCK_EN defined: non-preemptive; owner keeps the pin until it drops req regardless of higher-priority requests.
- Undefined: preemptive priority as in Operation.

## Structure
- Package evo_xb_pmux_pkg: state enum pmux_state_t {PMUX_IDLE, PMUX_OWNED, PMUX_SWITCH}, pin-index helper function (m*NUM_PINS+p).
- Sub-module evo_xb_pmux_pin: one FSM, dead-time counter, owner register, output registers; instantiated NUM_PINS times via generate. Top only slices/regroups vectors.

## Test plan
(NUM_PINS=8, MUX_WIDTH=4, DEADTIME=2)
- Reset: assert reset with req_i all-ones -> all outputs 0; release -> pin grants to channel 0 one cycle later, owner_o=0 per pin.
- Single owner: req channel 2 pin 5, dir=1, out toggling -> grant bit 2*8+5 after 1 cycle, port_out_o[5] follows out_i with 1-cycle lag, port_en_o[5]=1.
- Hand-over: channel 2 owns pin 5, channel 3 requests, channel 2 drops -> 2 cycles en=1/dir=0/no grant, then grant bit 3*8+5, owner_o pin 5 = 3.
- Preemption: channel 3 owns pin 0, channel 1 requests -> without EVO_XB_PMUX_LOCK_EN channel 1 granted after 2-cycle dead-time; with it channel 3 retains until release.
- Request vanishes in SWITCH: only other requester drops during dead-time -> pin goes IDLE, all pin outputs 0.
- Async reset mid-SWITCH -> outputs 0 immediately, FSM IDLE, no grant after release until req re-sampled.
